// File: rtl/image_window_streamer_pkg.sv
// Shared types and helpers for the sliding-window streamer: serialiser states and width math.
package image_window_streamer_pkg;

  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_SERIAL = 1'b1
  } winState_e;

  // Minimum of one bit so that degenerate depths still yield a legal vector width.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/image_window_streamer_line_buffer_ram.sv
// One image line of storage: simple dual-port RAM, synchronous read returning old data on collision.
module line_buffer_ram
  import image_window_streamer_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      wrEn,
  input  logic [clog2(DEPTH)-1:0]   wrAddr,
  input  logic [WIDTH-1:0]          wrData,
  input  logic                      rdEn,
  input  logic [clog2(DEPTH)-1:0]   rdAddr,
  output logic [WIDTH-1:0]          rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/image_window_streamer.sv
// Raster pixel stream in, every complete WIN_ROWS x WIN_COLS window out in parallel and,
// optionally, serialised element-by-element while the input is stalled.
//
//   state     | meaning
//   ST_STREAM | accepting pixels, windows presented in parallel only
//   ST_SERIAL | input stalled, window regs frozen, elements emitted on the serial port
module image_window_streamer
  import image_window_streamer_pkg::*;
#(
  parameter int WIN_COLS = 3,
  parameter int WIN_ROWS = 3,
  parameter int IM_COLS  = 64,
  parameter int IM_ROWS  = 48,
  parameter int BITWIDTH = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [BITWIDTH-1:0]                    in_data,
  input  logic                                   ser_en,
  output logic                                   win_valid,
  output logic [WIN_ROWS*WIN_COLS*BITWIDTH-1:0]  win_out,
  output logic [clog2(IM_COLS)-1:0]              win_x,
  output logic [clog2(IM_ROWS)-1:0]              win_y,
  output logic                                   ser_valid,
  input  logic                                   ser_ready,
  output logic [BITWIDTH-1:0]                    ser_data,
  output logic                                   ser_last
);

  localparam int XW = clog2(IM_COLS);
  localparam int YW = clog2(IM_ROWS);
  localparam int N  = WIN_ROWS * WIN_COLS;
  localparam int IW = clog2(N);
  localparam int NB = WIN_ROWS - 1;

  winState_e state, stateNext;
  logic [XW-1:0] xCnt, s1X;
  logic [YW-1:0] yCnt, s1Y;
  logic [BITWIDTH-1:0] s1Pix;
  logic s1Valid, s1Complete, accept;
  logic [IW-1:0] idx, idxNext;
  logic [BITWIDTH-1:0] lineQ  [NB];
  logic [BITWIDTH-1:0] newCol [WIN_ROWS];
  logic [BITWIDTH-1:0] winReg [WIN_ROWS][WIN_COLS];

  assign accept     = in_valid && in_ready && !flush;
  assign s1Complete = s1Valid && (s1Y >= YW'(WIN_ROWS - 1)) && (s1X >= XW'(WIN_COLS - 1));
  assign in_ready   = (state == ST_STREAM) && !(ser_en && s1Complete);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xCnt <= '0;
      yCnt <= '0;
    end else if (flush) begin
      xCnt <= '0;
      yCnt <= '0;
    end else if (accept) begin
      if (xCnt == XW'(IM_COLS - 1)) begin
        xCnt <= '0;
        yCnt <= (yCnt == YW'(IM_ROWS - 1)) ? '0 : yCnt + YW'(1);
      end else begin
        xCnt <= xCnt + XW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1Valid <= 1'b0;
      s1Pix   <= '0;
      s1X     <= '0;
      s1Y     <= '0;
    end else if (flush) begin
      s1Valid <= 1'b0;
    end else begin
      s1Valid <= accept;
      if (accept) begin
        s1Pix <= in_data;
        s1X   <= xCnt;
        s1Y   <= yCnt;
      end
    end
  end

  // Read on accept, write back in S1: the line chain ripples one line down per pixel.
  for (genvar k = 0; k < NB; k++) begin : gLine
    logic [BITWIDTH-1:0] wrData;
    if (k == 0) begin : gHead
      assign wrData = s1Pix;
    end else begin : gChain
      assign wrData = lineQ[k-1];
    end
    line_buffer_ram #(.DEPTH(IM_COLS), .WIDTH(BITWIDTH)) uRam (
      .clock  (clock),
      .wrEn   (s1Valid),
      .wrAddr (s1X),
      .wrData (wrData),
      .rdEn   (accept),
      .rdAddr (xCnt),
      .rdData (lineQ[k])
    );
  end

  always_comb begin
    for (int r = 0; r < WIN_ROWS - 1; r++) newCol[r] = lineQ[WIN_ROWS-2-r];
    newCol[WIN_ROWS-1] = s1Pix;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < WIN_ROWS; r++)
        for (int c = 0; c < WIN_COLS; c++)
          winReg[r][c] <= '0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
    end else if (flush) begin
      win_valid <= 1'b0;
    end else begin
      win_valid <= s1Complete;
      if (s1Valid) begin
        for (int r = 0; r < WIN_ROWS; r++) begin
          for (int c = 0; c < WIN_COLS - 1; c++) winReg[r][c] <= winReg[r][c+1];
          winReg[r][WIN_COLS-1] <= newCol[r];
        end
      end
      if (s1Complete) begin
        win_x <= s1X;
        win_y <= s1Y;
      end
    end
  end

  always_comb begin
    win_out = '0;
    for (int r = 0; r < WIN_ROWS; r++)
      for (int c = 0; c < WIN_COLS; c++)
        win_out[(r*WIN_COLS+c)*BITWIDTH +: BITWIDTH] = winReg[r][c];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_STREAM;
      idx   <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    ser_valid = 1'b0;
    ser_data  = '0;
    ser_last  = 1'b0;
    case (state)
      ST_STREAM: begin
        if (s1Complete && ser_en) begin
          stateNext = ST_SERIAL;
          idxNext   = '0;
        end
      end
      ST_SERIAL: begin
        ser_valid = 1'b1;
        ser_data  = win_out[int'(idx)*BITWIDTH +: BITWIDTH];
        ser_last  = (idx == IW'(N - 1));
        if (ser_ready) begin
          if (ser_last) begin
            stateNext = ST_STREAM;
            idxNext   = '0;
          end else begin
            idxNext = idx + IW'(1);
          end
        end
      end
      default: stateNext = ST_STREAM;
    endcase
    if (flush) begin
      stateNext = ST_STREAM;
      idxNext   = '0;
    end
  end

endmodule

// File: tb/tb_image_window_streamer.sv
// Scoreboard bench: a frame-array model predicts windows and serial beats; a monitor checks them.
module tb_image_window_streamer;

  localparam int WC = 3;
  localparam int WR = 3;
  localparam int IC = 8;
  localparam int IR = 6;
  localparam int BW = 8;
  localparam int NW = WC * WR;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [BW-1:0] in_data = '0;
  logic ser_en = 1'b0;
  logic win_valid;
  logic [NW*BW-1:0] win_out;
  logic [2:0] win_x, win_y;
  logic ser_valid;
  logic ser_ready = 1'b0;
  logic [BW-1:0] ser_data;
  logic ser_last;

  image_window_streamer #(
    .WIN_COLS(WC), .WIN_ROWS(WR), .IM_COLS(IC), .IM_ROWS(IR), .BITWIDTH(BW)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ser_en(ser_en), .win_valid(win_valid), .win_out(win_out),
    .win_x(win_x), .win_y(win_y), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_data(ser_data), .ser_last(ser_last)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Reference model: the current frame as a 2-D array, windows cut out by coordinates.
  typedef struct { logic [NW*BW-1:0] win; int x; int y; int cyc; } winExp_t;
  typedef struct { logic [BW-1:0] d; logic last; } serExp_t;
  winExp_t winQ[$];
  serExp_t serQ[$];
  logic [BW-1:0] img [IR][IC];
  int mx = 0, my = 0;

  function automatic void modelReset();
    winQ.delete();
    serQ.delete();
    mx = 0;
    my = 0;
  endfunction

  function automatic void modelAccept(input logic [BW-1:0] pix, input logic serMode, input int nowCyc);
    winExp_t e;
    img[my][mx] = pix;
    if (my >= WR - 1 && mx >= WC - 1) begin
      e.win = '0;
      for (int r = 0; r < WR; r++)
        for (int c = 0; c < WC; c++)
          e.win[(r*WC+c)*BW +: BW] = img[my-(WR-1)+r][mx-(WC-1)+c];
      e.x = mx;
      e.y = my;
      e.cyc = nowCyc + 2;
      winQ.push_back(e);
      if (serMode) begin
        for (int i = 0; i < NW; i++) begin
          serExp_t s;
          s.d = img[my-(WR-1)+i/WC][mx-(WC-1)+i%WC];
          s.last = (i == NW - 1);
          serQ.push_back(s);
        end
      end
    end
    mx++;
    if (mx == IC) begin
      mx = 0;
      my++;
      if (my == IR) my = 0;
    end
  endfunction

  // Monitor
  int winSeen = 0;
  int serBeats = 0;
  logic firstCaptured = 1'b0;
  logic [NW*BW-1:0] firstWin;
  logic [2:0] firstX, firstY;
  logic prevStall = 1'b0, lastDone = 1'b0, prevLast;
  logic [BW-1:0] prevData;
  winExp_t monE;
  serExp_t monS;

  always @(negedge clock) begin
    if (!reset) begin
      prevStall = 1'b0;
      lastDone = 1'b0;
    end else begin
      if (lastDone) begin
        check("in_ready after ser_last", in_ready, 1);
        lastDone = 1'b0;
      end
      if (win_valid) begin
        winSeen++;
        if (!firstCaptured) begin
          firstCaptured = 1'b1;
          firstWin = win_out;
          firstX = win_x;
          firstY = win_y;
        end
        if (winQ.size() == 0) report("unexpected win_valid");
        else begin
          monE = winQ.pop_front();
          check("win_out", win_out, monE.win);
          check("win_x", win_x, monE.x);
          check("win_y", win_y, monE.y);
          check("win latency cycle", cyc, monE.cyc);
        end
      end
      if (prevStall && ser_valid) begin
        check("ser_data stable in stall", ser_data, prevData);
        check("ser_last stable in stall", ser_last, prevLast);
      end
      if (ser_valid && ser_ready && !flush) begin
        serBeats++;
        if (serQ.size() == 0) report("unexpected serial beat");
        else begin
          monS = serQ.pop_front();
          check("ser_data", ser_data, monS.d);
          check("ser_last", ser_last, monS.last);
        end
        if (ser_last) lastDone = 1'b1;
      end
      prevStall = ser_valid && !ser_ready;
      prevData = ser_data;
      prevLast = ser_last;
    end
  end

  // Driver
  logic serToggle = 1'b0;

  task automatic step();
    @(posedge clock);
    #1;
    ser_ready = serToggle ? ~ser_ready : 1'b1;
  endtask

  task automatic sendPixel(input logic [BW-1:0] pix);
    int waited;
    logic comp, done;
    waited = 0;
    comp = 1'b0;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = pix;
    while (!done) begin
      @(negedge clock);
      if (in_ready && !flush) begin
        comp = (my >= WR - 1 && mx >= WC - 1);
        modelAccept(pix, ser_en, cyc);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          report("in_ready timeout");
          done = 1'b1;
        end
      end
      step();
    end
    in_valid = 1'b0;
    if (comp && ser_en) begin
      @(negedge clock);
      check("in_ready low while S1 holds completing pixel", in_ready, 0);
      step();
    end
  endtask

  task automatic sendFrame(input int gapPct, input logic det);
    for (int i = 0; i < IC * IR; i++) begin
      if (gapPct > 0) while ($urandom_range(99) < gapPct) step();
      sendPixel(det ? BW'(my * IC + mx) : BW'($urandom));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " in_ready"}, in_ready, 1);
    check({tag, " win_valid"}, win_valid, 0);
    check({tag, " win_out"}, win_out, 0);
    check({tag, " win_x"}, win_x, 0);
    check({tag, " win_y"}, win_y, 0);
    check({tag, " ser_valid"}, ser_valid, 0);
    check({tag, " ser_data"}, ser_data, 0);
    check({tag, " ser_last"}, ser_last, 0);
  endtask

  initial begin
    int guard;
    #1 reset = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    ser_ready = 1'b1;

    // Parallel mode, continuous stream, pixel = y*8+x
    winSeen = 0;
    sendFrame(0, 1'b1);
    repeat (4) step();
    check("frame1 window count", winSeen, 24);
    check("first window elements", firstWin, 72'h12_11_10_0A_09_08_02_01_00);
    check("first window x", firstX, 2);
    check("first window y", firstY, 2);

    // Second frame: frame wrap must not produce windows from stale lines
    winSeen = 0;
    sendFrame(0, 1'b1);
    repeat (4) step();
    check("frame2 window count", winSeen, 24);

    // Serial mode, consumer always ready
    ser_en = 1'b1;
    serBeats = 0;
    sendFrame(0, 1'b1);
    repeat (20) step();
    check("serial beats frame", serBeats, 24 * NW);

    // Serial mode, consumer ready toggling
    serToggle = 1'b1;
    sendFrame(0, 1'b0);
    repeat (40) step();
    serToggle = 1'b0;
    step();

    // Flush in the middle of a serialised window
    serBeats = 0;
    for (int i = 0; i < 19; i++) sendPixel(BW'($urandom));
    guard = 0;
    while (serBeats < 3 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) report("serial beats before flush timeout");
    flush = 1'b1;
    ser_ready = 1'b0;
    in_valid = 1'b1;
    in_data = BW'($urandom);
    @(negedge clock);
    check("ser_valid during flush cycle", ser_valid, 1);
    if (serQ.size() > 0) check("ser_data during flush cycle", ser_data, serQ[0].d);
    modelReset();
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    ser_en = 1'b0;
    @(negedge clock);
    check("ser_valid after flush", ser_valid, 0);
    check("in_ready after flush", in_ready, 1);
    step();

    // Fresh stream after flush, then reset asserted mid-stream
    for (int i = 0; i < 21; i++) sendPixel(BW'($urandom));
    in_valid = 1'b1;
    in_data = BW'($urandom);
    reset = 1'b0;
    #1 checkResetOutputs("mid-stream reset");
    modelReset();
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    step();

    // Random input gaps, deterministic then random pixel values
    winSeen = 0;
    sendFrame(50, 1'b1);
    repeat (4) step();
    check("gapped frame window count", winSeen, 24);
    sendFrame(50, 1'b0);
    repeat (10) step();

    check("window queue drained", winQ.size(), 0);
    check("serial queue drained", serQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
